mlp_pixel_loader: RTL and testbench

MLP_PIXEL_LOADER -- requirements
Module: mlp_pixel_loader

---
 rtl/mlp_pixel_loader.sv | 164 ++++++++++++++++
 tb/tb_mlp_pixel_loader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mlp_pixel_loader.sv
// Streams 8-bit pixels into a Q7.24 vector for a combinational MLP, waits for it to settle and hands off the class.
// Optional build macro MLP_LOADER_ZERO_FILL_EN: zero the unused tail of data_inputs on a short frame.
module mlp_pixel_loader #(
    parameter int INPUTS        = 784,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pix_valid,
    output logic               pix_ready,
    input  logic [7:0]         pix_data,
    input  logic               pix_last,
    output logic signed [31:0] data_inputs [INPUTS],
    output logic               vec_valid,
    input  logic [3:0]         predicted_class,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [3:0]         result_class,
    output logic               frame_err,
    output logic [15:0]        frames_done
);
    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_RESULT = 2'd3;

    localparam int             IDX_W       = (INPUTS > 1) ? $clog2(INPUTS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(INPUTS - 1);
    localparam logic [7:0]     SETTLE_INIT = 8'(SETTLE_CYCLES);
    localparam bit             ONE_ENTRY   = (INPUTS == 1);

    logic [1:0]         state_r, state_nxt_s;
    logic [IDX_W-1:0]   idx_r, idx_nxt_s;
    logic [7:0]         settle_r, settle_nxt_s;
    logic               frame_err_r, err_nxt_s;
    logic [3:0]         result_class_r, class_nxt_s;
    logic [15:0]        frames_done_r, done_nxt_s;
    logic               pix_ready_r, vec_valid_r, result_valid_r;
    logic               accept_s, is_last_idx_s, wr_en_s, short_s;
    logic signed [31:0] pix_word_s;
    logic signed [31:0] data_r [INPUTS];

    assign accept_s      = pix_valid && pix_ready_r;
    assign is_last_idx_s = (idx_r == IDX_LAST);
    // p/256 in Q7.24 is simply the pixel placed at bits 23:16
    assign pix_word_s    = $signed({8'h00, pix_data, 16'h0000});

    assign pix_ready     = pix_ready_r;
    assign vec_valid     = vec_valid_r;
    assign result_valid  = result_valid_r;
    assign result_class  = result_class_r;
    assign frame_err     = frame_err_r;
    assign frames_done   = frames_done_r;
    assign data_inputs   = data_r;

    // Next-state and datapath control decode
    always_comb begin
        state_nxt_s  = state_r;
        idx_nxt_s    = idx_r;
        settle_nxt_s = settle_r;
        err_nxt_s    = frame_err_r;
        class_nxt_s  = result_class_r;
        done_nxt_s   = frames_done_r;
        wr_en_s      = 1'b0;
        short_s      = 1'b0;
        case (state_r)
            ST_LOAD: begin
                if (accept_s) begin
                    wr_en_s = 1'b1;
                    if (is_last_idx_s && !pix_last && !ONE_ENTRY) begin
                        // Long frame: keep accepting but throw the excess away
                        err_nxt_s   = 1'b1;
                        state_nxt_s = ST_DRAIN;
                    end else if (pix_last || is_last_idx_s) begin
                        short_s      = !is_last_idx_s;
                        err_nxt_s    = frame_err_r | !is_last_idx_s;
                        settle_nxt_s = SETTLE_INIT;
                        state_nxt_s  = ST_SETTLE;
                    end else begin
                        idx_nxt_s = idx_r + IDX_W'(1);
                    end
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (accept_s && pix_last) begin
                    settle_nxt_s = SETTLE_INIT;
                    state_nxt_s  = ST_SETTLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_SETTLE: begin
                if (settle_r <= 8'd1) begin
                    settle_nxt_s = 8'd0;
                    class_nxt_s  = predicted_class;
                    state_nxt_s  = ST_RESULT;
                end else begin
                    settle_nxt_s = settle_r - 8'd1;
                end
            end
            ST_RESULT: begin
                if (result_ready) begin
                    done_nxt_s  = frames_done_r + 16'd1;
                    idx_nxt_s   = {IDX_W{1'b0}};
                    err_nxt_s   = 1'b0;
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_RESULT;
                end
            end
            default: begin
                state_nxt_s = ST_LOAD;
            end
        endcase
    end

    // Control state, counters and registered handshake flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_LOAD;
            idx_r          <= {IDX_W{1'b0}};
            settle_r       <= 8'd0;
            frame_err_r    <= 1'b0;
            result_class_r <= 4'd0;
            frames_done_r  <= 16'd0;
            pix_ready_r    <= 1'b1;
            vec_valid_r    <= 1'b0;
            result_valid_r <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            idx_r          <= idx_nxt_s;
            settle_r       <= settle_nxt_s;
            frame_err_r    <= err_nxt_s;
            result_class_r <= class_nxt_s;
            frames_done_r  <= done_nxt_s;
            pix_ready_r    <= (state_nxt_s == ST_LOAD) || (state_nxt_s == ST_DRAIN);
            vec_valid_r    <= (state_nxt_s == ST_SETTLE) || (state_nxt_s == ST_RESULT);
            result_valid_r <= (state_nxt_s == ST_RESULT);
        end
    end

    // Vector storage: pixel write plus optional tail clear on a short frame
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < INPUTS; k++) begin
                data_r[k] <= 32'sd0;
            end
        end else begin
            for (int k = 0; k < INPUTS; k++) begin
                if (wr_en_s && (IDX_W'(k) == idx_r)) begin
                    data_r[k] <= pix_word_s;
                end
`ifdef MLP_LOADER_ZERO_FILL_EN
                else if (wr_en_s && short_s && (IDX_W'(k) > idx_r)) begin
                    data_r[k] <= 32'sd0;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_mlp_pixel_loader.sv
// Directed bench for mlp_pixel_loader: full, short, long frames, backpressure, mid-frame reset, counter wrap.
module tb_mlp_pixel_loader;
    logic               clk = 1'b0;
    logic               rst;
    logic               pix_valid, pix_ready, pix_last;
    logic [7:0]         pix_data;
    logic signed [31:0] data_inputs [784];
    logic               vec_valid, result_valid, result_ready, frame_err;
    logic [3:0]         predicted_class, result_class;
    logic [15:0]        frames_done;

    logic               w_pix_valid, w_pix_ready, w_pix_last;
    logic [7:0]         w_pix_data;
    logic signed [31:0] w_data [1];
    logic               w_vec_valid, w_result_valid, w_result_ready, w_frame_err;
    logic [3:0]         w_pred, w_result_class;
    logic [15:0]        w_frames_done;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    mlp_pixel_loader #(.INPUTS(784), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .pix_last(pix_last), .data_inputs(data_inputs),
        .vec_valid(vec_valid), .predicted_class(predicted_class),
        .result_valid(result_valid), .result_ready(result_ready),
        .result_class(result_class), .frame_err(frame_err), .frames_done(frames_done)
    );

    mlp_pixel_loader #(.INPUTS(1), .SETTLE_CYCLES(1)) dut_wrap (
        .clk(clk), .rst(rst), .pix_valid(w_pix_valid), .pix_ready(w_pix_ready),
        .pix_data(w_pix_data), .pix_last(w_pix_last), .data_inputs(w_data),
        .vec_valid(w_vec_valid), .predicted_class(w_pred),
        .result_valid(w_result_valid), .result_ready(w_result_ready),
        .result_class(w_result_class), .frame_err(w_frame_err), .frames_done(w_frames_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int count_not(input logic [31:0] val, input int lo, input int hi);
        int bad = 0;
        for (int k = lo; k <= hi; k++) begin
            if (data_inputs[k] !== val) bad++;
        end
        return bad;
    endfunction

    // Present one pixel and hold it until accepted (bounded)
    task automatic push_pix(input logic [7:0] p, input logic last);
        int guard = 0;
        pix_valid = 1'b1;
        pix_data  = p;
        pix_last  = last;
        while (!pix_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!pix_ready) check_eq("pix_ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        pix_valid = 1'b0;
        pix_last  = 1'b0;
    endtask

    task automatic wait_result();
        int guard = 0;
        while (!result_valid && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!result_valid) check_eq("result_valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic handshake();
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
    endtask

    initial begin
        int guard;
        rst = 1'b1; pix_valid = 1'b0; pix_data = 8'h00; pix_last = 1'b0;
        predicted_class = 4'd0; result_ready = 1'b0;
        w_pix_valid = 1'b0; w_pix_data = 8'hA5; w_pix_last = 1'b0; w_pred = 4'd9; w_result_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check_eq("rst_pix_ready", 32'(pix_ready), 32'd1);
        check_eq("rst_vec_valid", 32'(vec_valid), 32'd0);
        check_eq("rst_result_valid", 32'(result_valid), 32'd0);
        check_eq("rst_result_class", 32'(result_class), 32'd0);
        check_eq("rst_frame_err", 32'(frame_err), 32'd0);
        check_eq("rst_frames_done", 32'(frames_done), 32'd0);
        check_eq("rst_data_nonzero", 32'(count_not(32'h0, 0, 783)), 32'd0);

        // Mid-frame reset after 400 pixels
        for (int i = 0; i < 400; i++) push_pix(8'h55, 1'b0);
        check_eq("mid_data399", data_inputs[399], 32'h00550000);
        check_eq("mid_pix_ready_in_load", 32'(pix_ready), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("mrst_pix_ready", 32'(pix_ready), 32'd1);
        check_eq("mrst_vec_valid", 32'(vec_valid), 32'd0);
        check_eq("mrst_data_nonzero", 32'(count_not(32'h0, 0, 783)), 32'd0);
        check_eq("mrst_frames_done", 32'(frames_done), 32'd0);

        // Full frame of 0x80
        predicted_class = 4'd3;
        for (int i = 0; i < 784; i++) push_pix(8'h80, i == 783);
        check_eq("full_vec_valid", 32'(vec_valid), 32'd1);
        check_eq("full_pix_ready_settle", 32'(pix_ready), 32'd0);
        check_eq("full_rv_lat0", 32'(result_valid), 32'd0);
        @(posedge clk); #1;
        check_eq("full_rv_lat1", 32'(result_valid), 32'd0);
        @(posedge clk); #1;
        check_eq("full_rv_lat2", 32'(result_valid), 32'd1);
        check_eq("full_class", 32'(result_class), 32'd3);
        check_eq("full_frame_err", 32'(frame_err), 32'd0);
        check_eq("full_data_bad", 32'(count_not(32'h00800000, 0, 783)), 32'd0);
        check_eq("full_pix_ready_result", 32'(pix_ready), 32'd0);
        handshake();
        check_eq("full_done", 32'(frames_done), 32'd1);
        check_eq("full_rv_after_hs", 32'(result_valid), 32'd0);
        check_eq("full_pix_ready_after_hs", 32'(pix_ready), 32'd1);
        check_eq("full_vec_after_hs", 32'(vec_valid), 32'd0);

        // Full frame of 0x10 with backpressure on the result
        predicted_class = 4'd7;
        for (int i = 0; i < 784; i++) push_pix(8'h10, i == 783);
        wait_result();
        predicted_class = 4'd2;
        for (int c = 0; c < 5; c++) begin
            check_eq("bp_result_valid", 32'(result_valid), 32'd1);
            check_eq("bp_class", 32'(result_class), 32'd7);
            check_eq("bp_pix_ready", 32'(pix_ready), 32'd0);
            @(posedge clk); #1;
        end
        check_eq("bp_done_before", 32'(frames_done), 32'd1);
        handshake();
        check_eq("bp_done_after", 32'(frames_done), 32'd2);
        check_eq("bp_data_bad", 32'(count_not(32'h00100000, 0, 783)), 32'd0);

        // Short frame: 100 pixels of 0xFF
        for (int i = 0; i < 100; i++) push_pix(8'hFF, i == 99);
        wait_result();
        check_eq("short_frame_err", 32'(frame_err), 32'd1);
        check_eq("short_data0", data_inputs[0], 32'h00FF0000);
        check_eq("short_data99", data_inputs[99], 32'h00FF0000);
`ifdef MLP_LOADER_ZERO_FILL_EN
        check_eq("short_data100", data_inputs[100], 32'h00000000);
        check_eq("short_data783", data_inputs[783], 32'h00000000);
`else
        check_eq("short_data100", data_inputs[100], 32'h00100000);
        check_eq("short_data783", data_inputs[783], 32'h00100000);
`endif
        handshake();
        check_eq("short_err_cleared", 32'(frame_err), 32'd0);
        check_eq("short_done", 32'(frames_done), 32'd3);

        // Long frame: 790 pixels with value i mod 256
        for (int i = 0; i < 784; i++) push_pix(8'(i), 1'b0);
        check_eq("long_drain_pix_ready", 32'(pix_ready), 32'd1);
        check_eq("long_drain_vec_valid", 32'(vec_valid), 32'd0);
        for (int i = 784; i < 790; i++) begin
            check_eq("long_drain_ready_held", 32'(pix_ready), 32'd1);
            push_pix(8'(i), i == 789);
        end
        check_eq("long_vec_valid", 32'(vec_valid), 32'd1);
        wait_result();
        check_eq("long_frame_err", 32'(frame_err), 32'd1);
        check_eq("long_data783", data_inputs[783], 32'h000F0000);
        check_eq("long_data700", data_inputs[700], 32'h00BC0000);
        check_eq("long_data0", data_inputs[0], 32'h00000000);
        handshake();
        check_eq("long_done", 32'(frames_done), 32'd4);

        // Single-entry instance: one frame without pix_last, then wrap the counter
        check_eq("w_rst_ready", 32'(w_pix_ready), 32'd1);
        w_pix_valid = 1'b1;
        @(posedge clk); #1;
        w_pix_valid = 1'b0;
        check_eq("w_vec_valid", 32'(w_vec_valid), 32'd1);
        check_eq("w_data0", w_data[0], 32'h00A50000);
        @(posedge clk); #1;
        check_eq("w_result_valid", 32'(w_result_valid), 32'd1);
        check_eq("w_class", 32'(w_result_class), 32'd9);
        check_eq("w_frame_err", 32'(w_frame_err), 32'd0);
        w_result_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("w_done1", 32'(w_frames_done), 32'd1);
        w_pix_valid = 1'b1;
        w_pix_last  = 1'b1;
        guard = 0;
        while (w_frames_done != 16'hFFFF && guard < 200000) begin
            @(posedge clk); #1;
            guard++;
        end
        check_eq("w_done_ffff", 32'(w_frames_done), 32'h0000FFFF);
        guard = 0;
        while (w_frames_done == 16'hFFFF && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        check_eq("w_done_wrap", 32'(w_frames_done), 32'd0);
        w_pix_valid = 1'b0;
        w_result_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
